grid_write_arbiter: RTL and testbench

Shares the single write port of the 64x48 GridData dual-port RAM (4-bit color index per cell, 12-bit address, read side owned by the VGA scan path) between several requesters. It also owns a built-in full-grid clear sequencer. It applies rotating-priority arbitration and drops out-of-range addresses. It drives the RAM's `wren`/`wraddress`/`data` inputs from registers, in the `iVGA_CLK` domain.

---
 rtl/grid_pkg.sv | 22 ++
 rtl/grid_write_arbiter_rr.sv | 41 ++++
 rtl/grid_write_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_grid_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared constants and types for the GridData write path (64x48 grid, 4-bit color index).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package grid_pkg;

    localparam int GRID_W     = 64;
    localparam int GRID_H     = 48;
    localparam int GRID_CELLS = GRID_W * GRID_H;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Requester index visited at search offset 'off' when the search starts at 'base'.
    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/grid_write_arbiter_rr.sv
// Rotating-priority grant: first asserted request searching ptr, ptr+1, ... mod NUM_REQ.
// Latency: combinational; the pointer itself is registered by the parent.
// Backpressure: en=0 forces an all-zero grant; requests simply stay pending.
//
// Ports:
//   req      per-requester request bits
//   ptr      requester with highest priority this cycle
//   en       grant enable
//   gnt      one-hot grant (zero when nothing granted)
//   gnt_idx  index of the granted requester (valid with gnt_vld)
//   gnt_vld  a grant was issued
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               gnt_vld
);
    import grid_pkg::*;

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_index(int'(ptr), i, NUM_REQ);
            if (en && !gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_write_arbiter.sv
// Shares the GridData RAM write port among NUM_REQ requesters and runs a full-grid clear.
// Latency: a transfer at edge E appears on wren/wraddress/data in cycle E+1; clear busy 3072 cycles.
// Backpressure: requesters hold iREQ until oGNT; no grants while clearing (or outside vblank with macro).
//
// Optional feature macro: GRID_WRITE_VBLANK_ONLY_EN
//   defined   -> grants and clear steps only happen while iVBLANK=1 (clear pauses, stays busy)
//   undefined -> iVBLANK ignored
//
// Ports:
//   iVGA_CLK, iRST_n          clock, asynchronous active-low reset
//   iREQ/iREQ_ADDR/iREQ_DATA  per-requester request with packed address/data slices
//   oGNT                      combinational one-hot grant; transfer = iREQ[i] & oGNT[i]
//   iCLEAR, oCLEAR_BUSY       clear start / clear in progress
//   iVBLANK                   vertical blanking (used only with the macro)
//   oWREN/oWRADDRESS/oWDATA   registered RAM write port
//   oDROP                     one-cycle pulse: granted write was out of range and discarded
module grid_write_arbiter #(
    parameter int                NUM_REQ     = 2,
    parameter int                GRID_W      = grid_pkg::GRID_W,
    parameter int                GRID_H      = grid_pkg::GRID_H,
    parameter int                ADDR_W      = grid_pkg::ADDR_W,
    parameter int                DATA_W      = grid_pkg::DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
    input  logic                      iVGA_CLK,
    input  logic                      iRST_n,
    input  logic [NUM_REQ-1:0]        iREQ,
    input  logic [NUM_REQ*ADDR_W-1:0] iREQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] iREQ_DATA,
    output logic [NUM_REQ-1:0]        oGNT,
    input  logic                      iCLEAR,
    output logic                      oCLEAR_BUSY,
    input  logic                      iVBLANK,
    output logic                      oWREN,
    output logic [ADDR_W-1:0]         oWRADDRESS,
    output logic [DATA_W-1:0]         oWDATA,
    output logic                      oDROP
);
    import grid_pkg::*;

    localparam int                PTR_W     = $clog2(NUM_REQ);
    localparam int unsigned       CELLS     = GRID_W * GRID_H;
    // One extra bit so the cell count itself is representable for the range compare.
    localparam logic [ADDR_W:0]   CELLS_W   = CELLS[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                drop_q, drop_d;

    // ------------------------------------------------------------------
    // Write-window qualifier
    // ------------------------------------------------------------------
    logic vblank_ok;

`ifdef GRID_WRITE_VBLANK_ONLY_EN
    assign vblank_ok = iVBLANK;
`else
    assign vblank_ok = 1'b1;
    logic unused_vblank;
    assign unused_vblank = iVBLANK;
`endif

    // ------------------------------------------------------------------
    // FSM output decode
    // ------------------------------------------------------------------
    logic arb_en;
    logic clr_step;

    always_comb begin
        arb_en      = 1'b0;
        clr_step    = 1'b0;
        oCLEAR_BUSY = 1'b0;
        case (state_q)
            IDLE: begin
                // iRST_n term keeps oGNT low while reset is asserted.
                arb_en = iRST_n & vblank_ok;
            end
            CLEAR: begin
                oCLEAR_BUSY = 1'b1;
                clr_step    = vblank_ok;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_vld;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req     (iREQ),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign oGNT = gnt;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_in_range;

    assign sel_addr     = iREQ_ADDR[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data     = iREQ_DATA[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_in_range = ({1'b0, sel_addr} < CELLS_W);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (iCLEAR) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                // A new iCLEAR here is ignored; the sweep always runs to completion.
                if (clr_step) begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Write port and pointer next values
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d    = ptr_q;
        wren_d   = 1'b0;
        drop_d   = 1'b0;
        wraddr_d = wraddr_q;
        wdata_d  = wdata_q;
        if (gnt_vld) begin
            // Grant is consumed even for an out-of-range address; only the strobe differs.
            wraddr_d = sel_addr;
            wdata_d  = sel_data;
            wren_d   = sel_in_range;
            drop_d   = ~sel_in_range;
            ptr_d    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end else if (clr_step) begin
            wraddr_d = clr_cnt_q;
            wdata_d  = CLEAR_COLOR;
            wren_d   = 1'b1;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ptr_q    <= '0;
            wren_q   <= 1'b0;
            drop_q   <= 1'b0;
            wraddr_q <= '0;
            wdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wren_q   <= wren_d;
            drop_q   <= drop_d;
            wraddr_q <= wraddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign oWREN      = wren_q;
    assign oWRADDRESS = wraddr_q;
    assign oWDATA     = wdata_q;
    assign oDROP      = drop_q;

endmodule

// File: tb/tb_grid_write_arbiter.sv
module tb_grid_write_arbiter;

    localparam int N     = 2;
    localparam int AW    = 12;
    localparam int DW    = 4;
    localparam int CELLS = 64 * 48;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            clear;
    logic            vblank;
    logic [N-1:0]    gnt;
    logic            busy;
    logic            wren;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic            drop;

    always #5 clk = ~clk;

    grid_write_arbiter #(.NUM_REQ(N)) dut (
        .iVGA_CLK    (clk),
        .iRST_n      (rst_n),
        .iREQ        (req),
        .iREQ_ADDR   (req_addr),
        .iREQ_DATA   (req_data),
        .oGNT        (gnt),
        .iCLEAR      (clear),
        .oCLEAR_BUSY (busy),
        .iVBLANK     (vblank),
        .oWREN       (wren),
        .oWRADDRESS  (waddr),
        .oWDATA      (wdata),
        .oDROP       (drop)
    );

    int n_tot  = 0;
    int n_pass = 0;

    // Reference model state: what the write port should show in the current cycle.
    bit m_busy;
    int m_cnt;
    int m_ptr;
    bit m_wren;
    bit m_drop;
    int m_addr;
    int m_data;
    bit m_ad_known;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_cnt = 0; m_ptr = 0;
        m_wren = 0; m_drop = 0; m_addr = 0; m_data = 0; m_ad_known = 1;
    endtask

    function automatic int model_gnt(input logic [N-1:0] r);
        if (m_busy) return 0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (r[k]) return 1 << k;
        end
        return 0;
    endfunction

    // Drive inputs, then wait to the falling edge where outputs are sampled.
    task automatic apply(input logic [N-1:0] r, input int a0, input int d0,
                         input int a1, input int d1, input logic c);
        req      = r;
        req_addr = {AW'(a1), AW'(a0)};
        req_data = {DW'(d1), DW'(d0)};
        clear    = c;
        @(negedge clk);
    endtask

    task automatic check_model();
        chk("gnt",  int'(gnt),  model_gnt(req));
        chk("busy", int'(busy), int'(m_busy));
        chk("wren", int'(wren), int'(m_wren));
        chk("drop", int'(drop), int'(m_drop));
        if (m_ad_known) begin
            chk("waddr", int'(waddr), m_addr);
            chk("wdata", int'(wdata), m_data);
        end
    endtask

    // Update the model for the coming rising edge, then cross it.
    task automatic advance();
        int g;
        g = model_gnt(req);
        if (!m_busy) begin
            if (g != 0) begin
                int k;
                int a;
                k = $clog2(g);
                a = int'(req_addr[k*AW +: AW]);
                m_addr     = a;
                m_data     = int'(req_data[k*DW +: DW]);
                m_wren     = (a < CELLS);
                m_drop     = !(a < CELLS);
                m_ad_known = (a < CELLS);
                m_ptr      = (k + 1) % N;
            end else begin
                m_wren = 0;
                m_drop = 0;
            end
            if (clear) begin
                m_busy = 1;
                m_cnt  = 0;
            end
        end else begin
            m_wren = 1; m_drop = 0; m_addr = m_cnt; m_data = 0; m_ad_known = 1;
            if (m_cnt == CELLS - 1) m_busy = 0;
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        int a0, d0, a1, d1;
        logic [N-1:0] gnt;
        logic wren;
        logic drop;
        logic ad;       // address/data columns are meaningful for this row
        int addr;
        int data;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int busy_cnt;
        int first_gnt;
        bit seen_idle;
        bit reached;

        tbl[0] = '{2'b11,    5,  3,   6, 7, 2'b01, 1'b0, 1'b0, 1'b1,    0, 0};
        tbl[1] = '{2'b11,    5,  3,   6, 7, 2'b10, 1'b1, 1'b0, 1'b1,    5, 3};
        tbl[2] = '{2'b11,    5,  3,   6, 7, 2'b01, 1'b1, 1'b0, 1'b1,    6, 7};
        tbl[3] = '{2'b10,    5,  3, 3072, 9, 2'b10, 1'b1, 1'b0, 1'b1,    5, 3};
        tbl[4] = '{2'b00,    0,  0,   0, 0, 2'b00, 1'b0, 1'b1, 1'b0,    0, 0};
        tbl[5] = '{2'b00,    0,  0,   0, 0, 2'b00, 1'b0, 1'b0, 1'b0,    0, 0};
        tbl[6] = '{2'b01,  100, 15,   0, 0, 2'b01, 1'b0, 1'b0, 1'b0,    0, 0};
        tbl[7] = '{2'b11,  100, 15, 200, 2, 2'b10, 1'b1, 1'b0, 1'b1,  100, 15};
        tbl[8] = '{2'b00,    0,  0,   0, 0, 2'b00, 1'b1, 1'b0, 1'b1,  200, 2};
        tbl[9] = '{2'b00,    0,  0,   0, 0, 2'b00, 1'b0, 1'b0, 1'b1,  200, 2};

        // ---------------- reset ----------------
        rst_n = 1'b0; vblank = 1'b1; clear = 1'b0;
        req = 2'b11; req_addr = {AW'(6), AW'(5)}; req_data = {DW'(7), DW'(3)};
        #12;
        chk("rst_gnt",   int'(gnt),   0);
        chk("rst_wren",  int'(wren),  0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_drop",  int'(drop),  0);
        chk("rst_busy",  int'(busy),  0);
        @(negedge clk);
        rst_n = 1'b1; req = '0;
        @(posedge clk);
        #1;
        model_reset();

        // ---------------- table: rotation, drop, hold ----------------
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].req, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, 1'b0);
            chk($sformatf("tbl%0d_gnt", i),  int'(gnt),  int'(tbl[i].gnt));
            chk($sformatf("tbl%0d_wren", i), int'(wren), int'(tbl[i].wren));
            chk($sformatf("tbl%0d_drop", i), int'(drop), int'(tbl[i].drop));
            chk($sformatf("tbl%0d_busy", i), int'(busy), 0);
            if (tbl[i].ad) begin
                chk($sformatf("tbl%0d_addr", i), int'(waddr), tbl[i].addr);
                chk($sformatf("tbl%0d_data", i), int'(wdata), tbl[i].data);
            end
            advance();
        end

        // ---------------- clear with req0 rising mid-sweep ----------------
        apply(2'b00, 0, 0, 0, 0, 1'b1);
        check_model();
        advance();
        busy_cnt = 0; first_gnt = -1; seen_idle = 0;
        for (int c = 0; c < 3200 && !seen_idle; c++) begin
            apply((c >= 1000) ? 2'b01 : 2'b00, 50, 6, 0, 0, 1'b0);
            if (busy) begin
                busy_cnt++;
                if (busy_cnt == 2) begin
                    chk("clr_first_addr", int'(waddr), 0);
                    chk("clr_first_wren", int'(wren), 1);
                end
            end else begin
                seen_idle = 1;
                first_gnt = int'(gnt);
                chk("clr_last_addr", int'(waddr), CELLS - 1);
            end
            check_model();
            advance();
        end
        chk("clr_busy_len", busy_cnt, CELLS);
        chk("clr_gnt_after", first_gnt, 1);
        apply(2'b00, 0, 0, 0, 0, 1'b0);
        chk("clr_req0_addr", int'(waddr), 50);
        check_model();
        advance();

        // ---------------- clear with same-cycle grant, ignored re-clear ----------------
        apply(2'b01, 10, 5, 0, 0, 1'b1);
        check_model();
        advance();
        apply(2'b00, 0, 0, 0, 0, 1'b0);
        chk("clr2_grant_addr", int'(waddr), 10);
        chk("clr2_grant_wren", int'(wren), 1);
        busy_cnt = 0; seen_idle = 0;
        for (int c = 0; c < 3200 && !seen_idle; c++) begin
            if (c > 0) apply(2'b00, 0, 0, 0, 0, 1'b0);
            if (busy && waddr == AW'(100)) begin
                clear = 1'b1;
                #1;
            end
            if (busy) busy_cnt++;
            else seen_idle = 1;
            check_model();
            advance();
        end
        chk("clr2_busy_len", busy_cnt, CELLS);

        // ---------------- async reset mid-clear ----------------
        apply(2'b00, 0, 0, 0, 0, 1'b1);
        check_model();
        advance();
        reached = 0;
        for (int c = 0; c < 4000 && !reached; c++) begin
            apply(2'b00, 0, 0, 0, 0, 1'b0);
            if (busy && wren && waddr == AW'(1500)) reached = 1;
            else begin
                check_model();
                advance();
            end
        end
        chk("abort_reached", int'(reached), 1);
        rst_n = 1'b0; req = 2'b11;
        #1;
        chk("abort_gnt",   int'(gnt),   0);
        chk("abort_busy",  int'(busy),  0);
        chk("abort_wren",  int'(wren),  0);
        chk("abort_waddr", int'(waddr), 0);
        chk("abort_wdata", int'(wdata), 0);
        chk("abort_drop",  int'(drop),  0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; req = '0;
        @(posedge clk);
        #1;
        model_reset();

        // ---------------- randomized traffic against the model ----------------
        for (int c = 0; c < 400; c++) begin
            int a0, a1;
            a0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3072, 4095)) : int'($urandom_range(0, 3071));
            a1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3072, 4095)) : int'($urandom_range(0, 3071));
            apply(N'($urandom_range(0, 3)), a0, int'($urandom_range(0, 15)),
                  a1, int'($urandom_range(0, 15)), 1'b0);
            check_model();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
